// File: rtl/mc_if.sv
// Control bus between the multicycle controller and its datapath: decoded
// instruction fields and status flags in, register/mux/ALU controls out.
interface mc_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       ArithmLog;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, ArithmLog, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, ArithmLog, Illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32 subset controller: state register plus state-decoded
// control outputs (lw, sw, R-type, I-ALU, branch, jal; anything else traps).
module mc_controller (
    input  logic clk,
    input  logic reset_n,
    mc_if.master bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_ILLEGAL
    } state_t;

    state_t state;
    logic   br_taken;

    // funct3=000 only subtracts for R-type; I-ALU has no subi.
    function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic f7,
                                             input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SR;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST:      state <= S_FETCH;
                S_FETCH:    if (bus.MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_JAL:       state <= S_JAL;
                        OP_BR:        state <= S_BRANCH;
                        default:      state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR:   state <= (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (bus.MemReady) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (bus.MemReady) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BRANCH:   state <= S_FETCH;
                S_ILLEGAL:  state <= S_ILLEGAL;
                default:    state <= S_RST;
            endcase
        end
    end

    // Only beq/bne are supported; other funct3 values never redirect the PC.
    assign br_taken = ((bus.funct3 == 3'b000) &&  bus.Zero) ||
                      ((bus.funct3 == 3'b001) && !bus.Zero);

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.ArithmLog  = 1'b0;
        bus.Illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.MemReady;
                bus.PCWrite   = bus.MemReady;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                bus.ALUControl = funct_alu(bus.funct3, bus.funct7b5, state == S_EXECR);
                bus.ArithmLog  = (bus.funct3 == 3'b101) && bus.funct7b5;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = ALU_SUB;
                bus.PCWrite    = br_taken;
            end
            S_ILLEGAL:  bus.Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected cycle sequences built from
// the instruction-class rules, directed scenarios first, then random programs.
module tb_mc_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] ALU_F3 [8] = '{4'b0000, 4'b0111, 4'b0101, 4'b1000,
                                          4'b0110, 4'b0100, 4'b0011, 4'b0010};
    localparam logic [18:0] IMM_MASK = 19'h000C0;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mc_if bus ();
    mc_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    logic [18:0] out_vec;
    assign out_vec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                      bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                      bus.ALUControl, bus.ArithmLog, bus.Illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BR)  return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [18:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] alu, input logic al, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm_of(bus.op), alu, al, ill};
    endfunction

    // Called at posedge+1 with inputs already set; checks, then advances one cycle.
    task automatic cyc(input string tag, input logic [18:0] e);
        #1 check_eq(tag, out_vec, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1 check_eq("reset_async", out_vec & ~IMM_MASK, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hold", out_vec & ~IMM_MASK, 0);
        reset_n = 1'b1;
        bus.op = 7'b0;
        bus.MemReady = 1'b1;
        cyc("rst_state", v(0,0,0,0,0,2'b00,2'b00,2'b00,ADD,0,0));
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int fstall, input int mstall, input logic z,
                             input bit abort_mem);
        logic [3:0] ex_alu;
        logic       ex_al;
        logic       pcw;
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        for (int i = 0; i < fstall; i++) begin
            bus.MemReady = 1'b0;
            cyc("fetch_wait", v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0,0));
        end
        bus.MemReady = 1'b1;
        cyc("fetch", v(1,0,0,1,0,2'b10,2'b00,2'b10,ADD,0,0));
        bus.MemReady = 1'($urandom_range(0, 1));
        cyc("decode", v(0,0,0,0,0,2'b00,2'b01,2'b01,ADD,0,0));
        ex_alu = (f3 == 3'b000) ? ((o == OP_R && f7) ? SUB : ADD) : ALU_F3[f3];
        ex_al  = (f3 == 3'b101) ? f7 : 1'b0;
        case (o)
            OP_LW, OP_SW: begin
                bus.MemReady = 1'($urandom_range(0, 1));
                cyc("memadr", v(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0,0));
                if (abort_mem) begin
                    bus.MemReady = 1'b0;
                    #1 check_eq("memwrite_strobe", bus.MemWrite, 1);
                    reset_n = 1'b0;
                    #1 check_eq("memwrite_async_clr", bus.MemWrite, 0);
                    return;
                end
                for (int i = 0; i < mstall; i++) begin
                    bus.MemReady = 1'b0;
                    cyc("mem_wait", v(0,1,o == OP_SW,0,0,2'b00,2'b00,2'b00,ADD,0,0));
                end
                bus.MemReady = 1'b1;
                cyc("mem_done", v(0,1,o == OP_SW,0,0,2'b00,2'b00,2'b00,ADD,0,0));
                if (o == OP_LW) begin
                    bus.MemReady = 1'($urandom_range(0, 1));
                    cyc("memwb", v(0,0,0,0,1,2'b01,2'b00,2'b00,ADD,0,0));
                end
            end
            OP_R, OP_I: begin
                bus.MemReady = 1'($urandom_range(0, 1));
                cyc(o == OP_R ? "execr" : "execi",
                    v(0,0,0,0,0,2'b00,2'b10,(o == OP_I) ? 2'b01 : 2'b00,ex_alu,ex_al,0));
                cyc("alu_wb", v(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0,0));
            end
            OP_JAL: begin
                bus.MemReady = 1'($urandom_range(0, 1));
                cyc("jal", v(1,0,0,0,0,2'b00,2'b01,2'b10,ADD,0,0));
                cyc("jal_wb", v(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0,0));
            end
            OP_BR: begin
                pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
                bus.MemReady = 1'($urandom_range(0, 1));
                cyc("branch", v(pcw,0,0,0,0,2'b00,2'b10,2'b00,SUB,0,0));
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    bus.MemReady = 1'($urandom_range(0, 1));
                    cyc("illegal", v(0,0,0,0,0,2'b00,2'b00,2'b00,ADD,0,1));
                end
            end
        endcase
    endtask

    initial begin
        logic [6:0] ops [6];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
        bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.MemReady = 1'b0;
        #2;
        do_reset();

        run_instr(OP_R,  3'b000, 1'b1, 0, 0, 1'b0, 1'b0);
        run_instr(OP_LW, 3'b010, 1'b0, 1, 3, 1'b0, 1'b0);
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0);
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BR, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0);
        run_instr(OP_I,  3'b101, 1'b1, 0, 0, 1'b0, 1'b0);
        run_instr(OP_I,  3'b000, 1'b1, 0, 0, 1'b0, 1'b0);
        run_instr(OP_R,  3'b101, 1'b0, 0, 0, 1'b0, 1'b0);
        run_instr(OP_SW, 3'b010, 1'b0, 2, 2, 1'b0, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);

        run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("illegal_sticky", bus.Illegal, 1);
        do_reset();

        run_instr(OP_SW, 3'b010, 1'b0, 0, 0, 1'b0, 1'b1);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The module SHALL have the following ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op  input  7  instruction opcode, instr[6:0].
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access complete this cycle.
- PCWrite  output  1  PC register load enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction/OldPC register load enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU Src_A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU Src_B select: 00 = rs2, 01 = Imm, 10 = constant 4.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  4  ALU operation code.
- ArithmLog  output  1  1 = arithmetic right shift.
- Illegal  output  1  unsupported opcode trapped.
REQ-002 The module SHALL use a single clock, clk; reset_n SHALL be asynchronous and active-low.

Function
REQ-003 ALUControl encoding SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 shift right, 0101 slt, 0110 xor, 0111 sll, 1000 sltu.
REQ-004 Supported opcodes SHALL be: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 branch, 1101111 jal.
REQ-005 The states SHALL be RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, ILLEGAL.
REQ-006 Outputs not listed for a state SHALL be 0, and ALUControl SHALL be 0000 in such states.
REQ-007 RST SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-008 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, with IRWrite=PCWrite=MemReady; it SHALL stay in FETCH while MemReady=0 and otherwise go to DECODE.
REQ-009 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch target), and transition by op: lw/sw -> MEMADR, R -> EXECR, I-ALU -> EXECI, jal -> JAL, branch -> BRANCH, other -> ILLEGAL.
REQ-010 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add, then go to MEMREAD if op=lw, else MEMWRITE.
REQ-011 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and hold until MemReady=1, then go to MEMWB.
REQ-012 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1, and hold until MemReady=1, then go to FETCH.
REQ-014 EXECR (ALUSrcA=10, ALUSrcB=00) and EXECI (ALUSrcA=10, ALUSrcB=01) SHALL drive the funct-decoded ALUControl, then go to ALUWB.
REQ-015 Funct decode SHALL be:
- funct3 000: add, or sub only when R-type and funct7b5=1.
- 001 sll; 010 slt; 011 sltu; 100 xor; 110 or; 111 and.
- 101 shift right with ArithmLog=funct7b5, for both R-type and I-ALU.
REQ-016 ArithmLog SHALL be 0 in every state/funct combination other than a funct3=101 execute.
REQ-017 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-018 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-019 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then go to FETCH.
REQ-020 In BRANCH, PCWrite SHALL be combinational: (funct3=000 & Zero) | (funct3=001 & ~Zero), and 0 for any other funct3.
REQ-021 ILLEGAL SHALL drive Illegal=1 with all strobes 0, and remain in ILLEGAL until reset.
REQ-022 ImmSrc SHALL decode combinationally from op in every state: sw 01, branch 10, jal 11, else 00.
REQ-023 op, funct3 and funct7b5 SHALL be treated as stable from DECODE to instruction end; the block SHALL NOT register them.

Reset
REQ-024 reset_n=0 SHALL force the state to RST asynchronously, including mid-instruction, with all outputs 0 immediately.
REQ-025 After reset_n rises, the first edge SHALL enter FETCH.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset release, MemReady=1, op=0110011 funct3=000 funct7b5=1 -> FETCH, DECODE, EXECR (ALUControl=0001), ALUWB (RegWrite=1), FETCH; 5 cycles.
- op=0000011 with MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with ResultSrc=01 and RegWrite=1.
- op=1100011 funct3=001, Zero=0 -> PCWrite=1 in BRANCH; Zero=1 -> PCWrite=0; ALUControl=0001 in both.
- op=0010011 funct3=101 funct7b5=1 -> EXECI with ALUControl=0100, ArithmLog=1; funct3=000 funct7b5=1 -> 0000 (add, not sub).
- op=0110111 -> ILLEGAL, Illegal=1 held 10 cycles; reset_n pulse -> Illegal=0 immediately.
- reset_n low during MEMWRITE with MemWrite=1 -> MemWrite=0 without waiting for a clock edge.
